// File: rtl/divisor_pkg.sv
// Shared constants for the sequential divider: FSM state encodings and default operand width.
// Latency: none (constants only).
// Backpressure: none.
package divisor_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD_LO  = 3'd1;
    localparam logic [2:0] ST_LOAD_DIV = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/divisor_seq_if.sv
// Operand entry and result bundle between the switch/button bank, the divider and the display logic.
// Latency: none (wires only).
// Backpressure: none; results are level signals qualified by done.
interface divisor_seq_if
    import divisor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                 btn;
    logic [WIDTH-1:0]     sw;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;

    modport master (
        output btn, sw,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  btn, sw,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/btn_edge.sv
// Turns a level push-button into a single-cycle pulse on its rising edge; optional 2-flop sync (DIVISOR_SEQ_BTN_SYNC_EN).
// Latency: pulse in the same cycle btn rises, or 2 clocks later with the synchronizer.
// Backpressure: none; holding btn high yields exactly one pulse.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    logic btn_s;
    logic btn_q;

`ifdef DIVISOR_SEQ_BTN_SYNC_EN
    logic [1:0] sync;

    // two-flop synchronizer for a button coming straight off the board
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], btn};
    end

    assign btn_s = sync[1];
`else
    // board debouncer already delivers a clean, synchronous level
    assign btn_s = btn;
`endif

    // previous button level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) btn_q <= 1'b0;
        else        btn_q <= btn_s;
    end

    assign pulse = btn_s & ~btn_q;
endmodule

// File: rtl/divisor_seq.sv
// Restoring divider: 2W-bit dividend / W-bit divisor, operands keyed in byte-wise; DIVISOR_SEQ_BTN_SYNC_EN adds btn sync.
// Latency: done rises 2*WIDTH clocks after the divisor is captured; divide-by-zero completes on the capture edge.
// Backpressure: button presses during RUN are ignored; results hold until the next completion.
module divisor_seq
    import divisor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    divisor_seq_if.slave  dbus
);
    localparam int CW = $clog2(2*WIDTH + 1);

    logic                 btn_pulse;
    logic [2:0]           state;
    logic [2*WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]     dvs;
    logic [WIDTH-1:0]     rem;
    logic [2*WIDTH-1:0]   quo;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]     remainder_r;
    logic                 div_by_zero_r;

    logic [WIDTH:0]       t;
    logic                 fits;
    logic [WIDTH-1:0]     rem_nxt;
    logic [2*WIDTH-1:0]   quo_nxt;

    btn_edge u_btn_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (dbus.btn),
        .pulse (btn_pulse)
    );

    // one restoring step: shift in the next dividend bit, subtract if the divisor fits
    always_comb begin
        t       = {rem, quo[2*WIDTH-1]};
        fits    = (t >= {1'b0, dvs});
        rem_nxt = fits ? (t[WIDTH-1:0] - dvs) : t[WIDTH-1:0];
        quo_nxt = {quo[2*WIDTH-2:0], fits};
    end

    // operand entry FSM and iterative datapath; result registers move only on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            dvd           <= '0;
            dvs           <= '0;
            rem           <= '0;
            quo           <= '0;
            cnt           <= '0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (btn_pulse) begin
                        dvd[2*WIDTH-1:WIDTH] <= dbus.sw;
                        state                <= ST_LOAD_LO;
                    end
                end
                ST_LOAD_LO: begin
                    if (btn_pulse) begin
                        dvd[WIDTH-1:0] <= dbus.sw;
                        state          <= ST_LOAD_DIV;
                    end
                end
                ST_LOAD_DIV: begin
                    if (btn_pulse) begin
                        dvs <= dbus.sw;
                        if (dbus.sw == '0) begin
                            quotient_r    <= '1;
                            remainder_r   <= dvd[WIDTH-1:0];
                            div_by_zero_r <= 1'b1;
                            state         <= ST_DONE;
                        end else begin
                            rem   <= '0;
                            quo   <= dvd;
                            cnt   <= CW'(2*WIDTH);
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient_r    <= quo_nxt;
                        remainder_r   <= rem_nxt;
                        div_by_zero_r <= 1'b0;
                        state         <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbus.quotient    = quotient_r;
    assign dbus.remainder   = remainder_r;
    assign dbus.div_by_zero = div_by_zero_r;
    assign dbus.busy        = (state == ST_RUN);
    assign dbus.done        = (state == ST_DONE);
endmodule

// File: tb/tb_divisor_seq.sv
// Self-checking bench for divisor_seq: directed cases plus random operands against a plain-arithmetic model.
// Latency: checks busy width of 2*WIDTH clocks and one-edge completion for divide-by-zero.
// Backpressure: exercises held button, presses during RUN and reset mid-RUN.
module tb_divisor_seq;
    localparam int W = 8;

`ifdef DIVISOR_SEQ_BTN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [2*W-1:0] prev_q;
    logic [W-1:0]   prev_r;

    divisor_seq_if #(.WIDTH(W)) dbus ();

    divisor_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbus  (dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // key one byte, holding the button for 'hold' cycles
    task automatic press(input logic [W-1:0] b, input int hold);
        @(negedge clk);
        dbus.sw  = b;
        dbus.btn = 1'b1;
        repeat (hold) @(negedge clk);
        dbus.btn = 1'b0;
    endtask

    // full operation: load three bytes, optionally poke btn mid-RUN, then check results against the model
    task automatic run_op(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo,
                          input logic [W-1:0] dv, input int hold_hi, input bit poke_run);
        int unsigned dividend;
        int unsigned exp_q;
        int unsigned exp_r;
        int          busy_cnt;
        int          cyc;
        int          dz_cyc;
        bit          hold_checked;
        bit          got_done;
        dividend = {hi, lo};
        if (dv == 0) begin
            exp_q = 32'hFFFF;
            exp_r = lo;
        end else begin
            exp_q = dividend / dv;
            exp_r = dividend % dv;
        end
        press(hi, hold_hi);
        check_val({tag, "_hold_q"}, dbus.quotient, prev_q);
        press(lo, 1);
        @(negedge clk);
        dbus.sw  = dv;
        dbus.btn = 1'b1;
        busy_cnt     = 0;
        hold_checked = 0;
        got_done     = 0;
        dz_cyc       = 0;
        for (cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (cyc == 1) dbus.btn = 1'b0;
            if (poke_run && busy_cnt == 5) begin
                dbus.sw  = 8'h77;
                dbus.btn = 1'b1;
            end
            if (poke_run && busy_cnt == 7) dbus.btn = 1'b0;
            if (dbus.busy) begin
                busy_cnt++;
                if (!hold_checked) begin
                    hold_checked = 1;
                    check_val({tag, "_run_r"}, dbus.remainder, prev_r);
                end
            end
            if (dbus.done) begin
                got_done = 1;
                dz_cyc   = cyc;
                break;
            end
        end
        dbus.btn = 1'b0;
        check_val({tag, "_done"}, got_done, 1);
        check_val({tag, "_q"}, dbus.quotient, exp_q);
        check_val({tag, "_r"}, dbus.remainder, exp_r);
        check_val({tag, "_dz"}, dbus.div_by_zero, (dv == 0));
        if (dv == 0) begin
            check_val({tag, "_dz_lat"}, dz_cyc, 1 + SYNC_LAT);
            check_val({tag, "_busy0"}, busy_cnt, 0);
        end else begin
            check_val({tag, "_busy"}, busy_cnt, 2*W);
        end
        prev_q = exp_q[2*W-1:0];
        prev_r = exp_r[W-1:0];
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_q"}, dbus.quotient, 0);
        check_val({tag, "_r"}, dbus.remainder, 0);
        check_val({tag, "_busy"}, dbus.busy, 0);
        check_val({tag, "_done"}, dbus.done, 0);
        check_val({tag, "_dz"}, dbus.div_by_zero, 0);
    endtask

    initial begin
        int waited;
        logic [W-1:0] rh, rl, rd;
        checks   = 0;
        failures = 0;
        prev_q   = '0;
        prev_r   = '0;
        dbus.btn = 1'b0;
        dbus.sw  = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // held button in IDLE loads only the high byte
        run_op("hold", 8'hAB, 8'hCD, 8'h05, 5, 0);
        run_op("t1", 8'h00, 8'h06, 8'h03, 1, 0);
        run_op("t2", 8'h03, 8'hE8, 8'h07, 1, 0);
        run_op("t3a", 8'hFF, 8'hFF, 8'hFF, 1, 0);
        run_op("t3b", 8'hFF, 8'hFF, 8'h01, 1, 0);
        run_op("t4", 8'h12, 8'h34, 8'h00, 1, 0);
        run_op("t4clr", 8'h00, 8'h64, 8'h0A, 1, 0);
        run_op("poke", 8'h03, 8'hE8, 8'h07, 1, 1);

        // reset in the middle of RUN
        press(8'h7F, 1);
        press(8'h21, 1);
        press(8'h0B, 1);
        waited = 0;
        while (!dbus.busy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val("rst_busy_seen", dbus.busy, 1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst_n  = 1'b1;
        prev_q = '0;
        prev_r = '0;
        run_op("post_rst", 8'h00, 8'h09, 8'h02, 1, 0);

        for (int i = 0; i < 24; i++) begin
            rh = 8'($urandom);
            rl = 8'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            run_op("rand", rh, rl, rd, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
